// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver oversampled on a 16x baud tick, feeding a
// first-word-fall-through byte FIFO with sticky overrun and framing-error flags.
module uart_rx_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              baudclk16,
    input  logic              rxd,
    input  logic              rd_strobe,
    input  logic              clear_err,
    output logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic [ADDR_W:0]   rx_count,
    output logic              overrun,
    output logic              frame_err
);
    localparam int DEPTH = 2**ADDR_W;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t            state, state_n;
    logic              rxd_m, rxd_s, rd_q;
    logic [3:0]        cnt, cnt_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        shreg, shreg_n;
    logic              byte_done, bad_stop, pop, push, full;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_m   <= 1'b1;
            rxd_s   <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            rxd_m   <= rxd;
            rxd_s   <= rxd_m;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
        end
    end
    // The sample counter wraps 15->0 by itself, so DATA needs no explicit clear between bits.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        byte_done = 1'b0;
        bad_stop  = 1'b0;
        if (baudclk16) begin
            cnt_n = cnt + 4'd1;
            case (state)
                IDLE: begin
                    cnt_n   = '0;
                    state_n = rxd_s ? IDLE : START;
                end
                START: if (cnt == 4'd7) begin
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    state_n   = rxd_s ? IDLE : DATA;
                end
                DATA: if (cnt == 4'd15) begin
                    shreg_n   = {rxd_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    state_n   = (bit_cnt == 3'd7) ? STOP : DATA;
                end
                STOP: if (cnt == 4'd15) begin
                    byte_done = rxd_s;
                    bad_stop  = !rxd_s;
                    state_n   = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    assign full     = rx_count == (ADDR_W+1)'(DEPTH);
    assign rx_ready = rx_count != '0;
    assign pop      = rd_strobe && !rd_q && rx_ready;
    assign push     = byte_done && (!full || pop);
    assign rx_data  = rx_ready ? mem[rd_ptr] : 8'h00;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= shreg;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rx_count  <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rd_q      <= rd_strobe;
            wr_ptr    <= wr_ptr + ADDR_W'(push);
            rd_ptr    <= rd_ptr + ADDR_W'(pop);
            rx_count  <= rx_count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
            overrun   <= !clear_err && (overrun || (byte_done && full && !pop));
            frame_err <= !clear_err && (frame_err || bad_stop);
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized frame-level bench for uart_rx_fifo, checked against a
// queue model of the receive FIFO and its sticky flags.
module tb_uart_rx_fifo;
    localparam int TICK     = 4;
    localparam int BIT      = 16*TICK;
    localparam int PUSH_OFF = 152*TICK;
    logic       clk = 0, reset = 1, baudclk16, rxd = 1, rd_strobe = 0, clear_err = 0;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [4:0] rx_count;
    logic       overrun, frame_err;
    int         checks = 0, failures = 0, cyc = 0, tcnt = 0, start_cyc = 0;
    bit         started = 0, exp_ovr = 0, exp_fe = 0;
    logic [7:0] q[$];

    uart_rx_fifo #(.ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .baudclk16(baudclk16), .rxd(rxd),
        .rd_strobe(rd_strobe), .clear_err(clear_err), .rx_data(rx_data),
        .rx_ready(rx_ready), .rx_count(rx_count), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        tcnt <= (tcnt == TICK-1) ? 0 : tcnt + 1;
    end
    assign baudclk16 = (tcnt == 0);

    // Start bit begins so that the DUT's first tick sees it exactly two clocks later;
    // the stop-bit mid-sample then lands on the edge ending cycle start_cyc+3+PUSH_OFF.
    task automatic send_frame(input logic [7:0] b, input bit good);
        @(negedge clk);
        while (tcnt != TICK-2) @(negedge clk);
        start_cyc = cyc;
        started = 1;
        rxd = 0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = good;
        repeat (good ? BIT : 12*TICK) @(negedge clk);
        rxd = 1;
        if (!good) repeat (20*TICK) @(negedge clk);
    endtask

    task automatic pulse_read(input int hold);
        rd_strobe = 1;
        repeat (hold) @(negedge clk);
        rd_strobe = 0;
        @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) exp_fe = 1;
        else if (q.size() < 16) q.push_back(b);
        else exp_ovr = 1;
    endtask

    task automatic test_reset;
        repeat (4) @(negedge clk);
        checks++; if (rx_count !== 0) begin failures++; $display("FAIL reset_count: got %0d want 0", rx_count); end
        checks++; if (rx_ready !== 0 || rx_data !== 0) begin failures++; $display("FAIL reset_data: ready=%b data=%h want 0/00", rx_ready, rx_data); end
        checks++; if (overrun !== 0 || frame_err !== 0) begin failures++; $display("FAIL reset_flags: ovr=%b fe=%b want 0/0", overrun, frame_err); end
        reset = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single;
        started = 0;
        fork
            send_frame(8'hA5, 1);
            begin
                wait (started);
                for (int k = 0; k < PUSH_OFF + 50 && cyc != start_cyc + 2 + PUSH_OFF; k++) @(negedge clk);
                checks++; if (cyc != start_cyc + 2 + PUSH_OFF || rx_count !== 0) begin failures++; $display("FAIL single_pre_push: count=%0d want 0", rx_count); end
                @(negedge clk);
                checks++; if (rx_count !== 1 || rx_ready !== 1) begin failures++; $display("FAIL single_push_timing: count=%0d ready=%b want 1/1", rx_count, rx_ready); end
                checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL single_data: got %h want a5", rx_data); end
            end
        join
        model_frame(8'hA5, 1);
        pulse_read(2);
        void'(q.pop_front());
        checks++; if (rx_count !== 0 || rx_ready !== 0 || rx_data !== 0) begin failures++; $display("FAIL single_read: count=%0d ready=%b data=%h want 0/0/00", rx_count, rx_ready, rx_data); end
    endtask

    task automatic test_glitch;
        @(negedge clk);
        rxd = 0;
        repeat (3*TICK) @(negedge clk);
        rxd = 1;
        repeat (30*TICK) @(negedge clk);
        checks++; if (rx_count !== 0 || frame_err !== 0) begin failures++; $display("FAIL glitch: count=%0d fe=%b want 0/0", rx_count, frame_err); end
    endtask

    task automatic test_framing;
        send_frame(8'h3C, 0);
        model_frame(8'h3C, 0);
        checks++; if (frame_err !== exp_fe || rx_count !== 0) begin failures++; $display("FAIL framing: fe=%b count=%0d want 1/0", frame_err, rx_count); end
        clear_err = 1;
        @(negedge clk);
        clear_err = 0;
        exp_fe = 0;
        @(negedge clk);
        checks++; if (frame_err !== 0) begin failures++; $display("FAIL framing_clear: fe=%b want 0", frame_err); end
    endtask

    task automatic test_fill;
        for (int i = 0; i <= 16; i++) begin
            send_frame(8'(i), 1);
            model_frame(8'(i), 1);
        end
        checks++; if (rx_count !== 16 || overrun !== exp_ovr) begin failures++; $display("FAIL fill: count=%0d ovr=%b want 16/1", rx_count, overrun); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (rx_data !== q[0]) begin failures++; $display("FAIL fill_read%0d: got %h want %h", i, rx_data, q[0]); end
            pulse_read(1 + i % 3);
            void'(q.pop_front());
        end
        checks++; if (rx_ready !== 0 || rx_count !== 0) begin failures++; $display("FAIL fill_empty: ready=%b count=%0d want 0/0", rx_ready, rx_count); end
        pulse_read(1);
        checks++; if (rx_count !== 0 || rx_data !== 0) begin failures++; $display("FAIL empty_pop: count=%0d data=%h want 0/00", rx_count, rx_data); end
        clear_err = 1;
        @(negedge clk);
        clear_err = 0;
        exp_ovr = 0;
        @(negedge clk);
        checks++; if (overrun !== 0) begin failures++; $display("FAIL ovr_clear: ovr=%b want 0", overrun); end
    endtask

    task automatic test_full_pop;
        logic [7:0] last;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b = 8'($urandom);
            send_frame(b, 1);
            model_frame(b, 1);
        end
        last = 8'($urandom);
        started = 0;
        fork
            send_frame(last, 1);
            begin
                wait (started);
                for (int k = 0; k < PUSH_OFF + 50 && cyc != start_cyc + 2 + PUSH_OFF; k++) @(negedge clk);
                checks++; if (rx_count !== 16 || rx_data !== q[0]) begin failures++; $display("FAIL fullpop_pre: count=%0d data=%h want 16/%h", rx_count, rx_data, q[0]); end
                rd_strobe = 1;
                repeat (2) @(negedge clk);
                rd_strobe = 0;
            end
        join
        void'(q.pop_front());
        q.push_back(last);
        checks++; if (rx_count !== 16 || overrun !== 0) begin failures++; $display("FAIL fullpop: count=%0d ovr=%b want 16/0", rx_count, overrun); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (rx_data !== q[0]) begin failures++; $display("FAIL fullpop_read%0d: got %h want %h", i, rx_data, q[0]); end
            pulse_read(2);
            void'(q.pop_front());
        end
        checks++; if (rx_count !== 0) begin failures++; $display("FAIL fullpop_drain: count=%0d want 0", rx_count); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 8; n++) begin
            logic [7:0] b = 8'($urandom);
            bit good = $urandom_range(0, 3) != 0;
            send_frame(b, good);
            model_frame(b, good);
            checks++; if (rx_count !== 5'(q.size()) || frame_err !== exp_fe || overrun !== exp_ovr) begin failures++; $display("FAIL rand_frame%0d: count=%0d fe=%b ovr=%b want %0d/%b/%b", n, rx_count, frame_err, overrun, q.size(), exp_fe, exp_ovr); end
            for (int r = $urandom_range(0, 2); r > 0; r--) begin
                checks++; if (rx_data !== (q.size() ? q[0] : 8'h00)) begin failures++; $display("FAIL rand_data%0d: got %h want %h", n, rx_data, q.size() ? q[0] : 8'h00); end
                pulse_read($urandom_range(1, 3));
                if (q.size()) void'(q.pop_front());
            end
        end
        clear_err = 1;
        @(negedge clk);
        clear_err = 0;
        exp_fe = 0;
        exp_ovr = 0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] b = 8'($urandom);
        while (q.size() < 3) begin
            logic [7:0] x = 8'($urandom);
            send_frame(x, 1);
            model_frame(x, 1);
        end
        checks++; if (rx_count !== 5'(q.size())) begin failures++; $display("FAIL resetmid_pre: count=%0d want %0d", rx_count, q.size()); end
        @(negedge clk);
        rxd = 0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = b[4];
        repeat (BIT/2) @(negedge clk);
        reset = 1;
        #1;
        q.delete();
        checks++; if (rx_count !== 0 || rx_ready !== 0 || rx_data !== 0 || overrun !== 0 || frame_err !== 0) begin failures++; $display("FAIL resetmid_async: count=%0d ready=%b data=%h ovr=%b fe=%b want all 0", rx_count, rx_ready, rx_data, overrun, frame_err); end
        rxd = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (40*TICK) @(negedge clk);
        send_frame(8'h5A, 1);
        model_frame(8'h5A, 1);
        checks++; if (rx_count !== 1 || rx_data !== 8'h5A || frame_err !== 0) begin failures++; $display("FAIL resetmid_after: count=%0d data=%h fe=%b want 1/5a/0", rx_count, rx_data, frame_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_framing();
        test_fill();
        test_full_pop();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
